// File: rtl/filter_pkg.sv
// Shared mode encodings and sizing helper for the multi-channel glitch filter.
package filter_pkg;

    localparam logic MODE_UNANIMOUS = 1'b0;
    localparam logic MODE_THRESH    = 1'b1;

    // Bits needed to hold a ones-count from 0 to n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/filter_multi_if.sv
// Raw inputs, mode select and filtered outputs of the glitch filter.
interface filter_multi_if #(
    parameter int CHANNELS = 4
) ();
    logic [CHANNELS-1:0] sig_in;
    logic                mode;
    logic [CHANNELS-1:0] sig_out;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic                tick;

    modport master (output sig_in, mode, input sig_out, rise, fall, tick);
    modport slave  (input sig_in, mode, output sig_out, rise, fall, tick);
endinterface

// File: rtl/filter_channel.sv
// One filter channel: sample window, ones-count, decision with hold, edge pulses.
module filter_channel
    import filter_pkg::*;
#(
    parameter int WINDOW    = 4,
    parameter int HI_THRESH = 3,
    parameter int LO_THRESH = 1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_en,
    input  logic i_sig,
    input  logic i_mode,
    output logic o_sig_out,
    output logic o_rise,
    output logic o_fall
);
    localparam int OW = cnt_width(WINDOW);

    logic [WINDOW-1:0] r_win;
    logic              r_out;
    logic              r_rise;
    logic              r_fall;
    logic [WINDOW-1:0] w_win_next;
    logic [OW-1:0]     w_ones;
    logic              w_out_next;

    assign w_win_next = {r_win[WINDOW-2:0], i_sig};

    always_comb begin
        w_ones = '0;
        for (int k = 0; k < WINDOW; k++) begin
            w_ones = w_ones + OW'(w_win_next[k]);
        end
    end

    // Any count between the two decision points keeps the previous level.
    always_comb begin
        w_out_next = r_out;
        if (i_en) begin
            if (i_mode == MODE_UNANIMOUS) begin
                if (w_ones == OW'(WINDOW))
                    w_out_next = 1'b1;
                else if (w_ones == '0)
                    w_out_next = 1'b0;
            end else begin
                if (w_ones >= OW'(HI_THRESH))
                    w_out_next = 1'b1;
                else if (w_ones <= OW'(LO_THRESH))
                    w_out_next = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_win  <= '0;
            r_out  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            if (i_en)
                r_win <= w_win_next;
            r_out  <= w_out_next;
            r_rise <= ~r_out & w_out_next;
            r_fall <= r_out & ~w_out_next;
        end
    end

    assign o_sig_out = r_out;
    assign o_rise    = r_rise;
    assign o_fall    = r_fall;
endmodule

// File: rtl/filter_multi.sv
// Multi-channel glitch filter: shared sample prescaler feeding CHANNELS filter slices.
module filter_multi
    import filter_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int WINDOW    = 4,
    parameter int HI_THRESH = 3,
    parameter int LO_THRESH = 1,
    parameter int DIV       = 1
) (
    input  logic           i_clock,
    input  logic           i_reset,
    filter_multi_if.slave  bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    if (CHANNELS < 1) begin : g_bad_channels
        $error("filter_multi: CHANNELS must be >= 1");
    end
    if (WINDOW < 2 || WINDOW > 16) begin : g_bad_window
        $error("filter_multi: WINDOW must be 2..16");
    end
    if (LO_THRESH < 0 || LO_THRESH >= HI_THRESH || HI_THRESH > WINDOW) begin : g_bad_thresh
        $error("filter_multi: need 0 <= LO_THRESH < HI_THRESH <= WINDOW");
    end
    if (DIV < 1) begin : g_bad_div
        $error("filter_multi: DIV must be >= 1");
    end

    logic [CW-1:0] r_count;
    logic          r_tick;
    logic          w_en;

    assign w_en = (r_count == CW'(DIV - 1));

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_count <= w_en ? '0 : r_count + CW'(1);
            r_tick  <= w_en;
        end
    end

    assign bus.tick = r_tick;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        filter_channel #(
            .WINDOW    (WINDOW),
            .HI_THRESH (HI_THRESH),
            .LO_THRESH (LO_THRESH)
        ) u_ch (
            .i_clock   (i_clock),
            .i_reset   (i_reset),
            .i_en      (w_en),
            .i_sig     (bus.sig_in[g]),
            .i_mode    (bus.mode),
            .o_sig_out (bus.sig_out[g]),
            .o_rise    (bus.rise[g]),
            .o_fall    (bus.fall[g])
        );
    end
endmodule
